// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - Sequencing front-end for the pipelined unsigned divider (RV64M DIV/REM, W-forms).
module div_ctrl #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [1:0]       op_i,
  input  logic             word_i,
  input  logic [XLEN-1:0]  op_a_i,
  input  logic [XLEN-1:0]  op_b_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             flush_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [XLEN-1:0]  result_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             div_req_o,
  output logic [XLEN-1:0]  div_op_a_o,
  output logic [XLEN-1:0]  div_op_b_o,
  input  logic [XLEN-1:0]  div_quotient_i,
  input  logic [XLEN-1:0]  div_remainder_i,
  input  logic             div_done_i
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, DRAIN} state_e;

  localparam logic [XLEN-1:0] MIN_D = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN_W = {{(XLEN-31){1'b1}}, {31{1'b0}}};

  state_e             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic               word_q, word_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic               sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic [XLEN-1:0]    a_q, a_d, b_q, b_d, result_q, result_d;

  logic               in_signed, accept, zero_div, ovf;
  logic               in_sign_a, in_sign_b;
  logic [XLEN-1:0]    ext_a, ext_b;

  function automatic logic [XLEN-1:0] form_result(
    input logic [1:0]      op,
    input logic            word,
    input logic            neg_q,
    input logic            neg_r,
    input logic [XLEN-1:0] q,
    input logic [XLEN-1:0] r
  );
    logic [XLEN-1:0] sel;
    sel = op[1] ? (neg_r ? -r : r) : (neg_q ? -q : q);
    if (word) sel = {{(XLEN-32){sel[31]}}, sel[31:0]};
    return sel;
  endfunction

  // DIV and REM (op 0 and 2) are the signed variants.
  assign in_signed = ~op_i[0];
  assign req_ready_o = (state_q == IDLE) & ~flush_i & rst_ni;
  assign accept = req_valid_i & req_ready_o;

  always_comb begin
    ext_a = op_a_i;
    ext_b = op_b_i;
    if (word_i) begin
      ext_a = {{(XLEN-32){in_signed & op_a_i[31]}}, op_a_i[31:0]};
      ext_b = {{(XLEN-32){in_signed & op_b_i[31]}}, op_b_i[31:0]};
    end
  end

  assign in_sign_a = in_signed & ext_a[XLEN-1];
  assign in_sign_b = in_signed & ext_b[XLEN-1];
  assign zero_div  = (ext_b == '0);
  assign ovf       = in_signed & (ext_b == '1) & (ext_a == (word_i ? MIN_W : MIN_D));

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    word_d   = word_q;
    tag_d    = tag_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d   = op_i;
          word_d = word_i;
          tag_d  = tag_i;
          if (zero_div) begin
            result_d = form_result(op_i, word_i, 1'b0, 1'b0, '1, ext_a);
            state_d  = RESP;
          end else if (ovf) begin
            result_d = form_result(op_i, word_i, 1'b0, 1'b0, ext_a, '0);
            state_d  = RESP;
          end else begin
            sign_a_d = in_sign_a;
            sign_b_d = in_sign_b;
            a_d      = in_sign_a ? -ext_a : ext_a;
            b_d      = in_sign_b ? -ext_b : ext_b;
            state_d  = ISSUE;
          end
        end
      end
      ISSUE, WAIT: begin
        // A done pulse coinciding with a flush is the in-flight result; dropping it leaves nothing to drain.
        if (flush_i) begin
          state_d = div_done_i ? IDLE : DRAIN;
        end else if (div_done_i) begin
          result_d = form_result(op_q, word_q, sign_a_q ^ sign_b_q, sign_a_q,
                                 div_quotient_i, div_remainder_i);
          state_d  = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      RESP: begin
        if (flush_i || resp_ready_i) state_d = IDLE;
      end
      DRAIN: begin
        if (div_done_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      op_q     <= '0;
      word_q   <= 1'b0;
      tag_q    <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      word_q   <= word_d;
      tag_q    <= tag_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

  assign div_req_o    = (state_q == ISSUE);
  assign resp_valid_o = (state_q == RESP);
  assign div_op_a_o   = a_q;
  assign div_op_b_o   = b_q;
  assign result_o     = result_q;
  assign tag_o        = tag_q;

endmodule
